condunit: RTL and testbench

Conditional-execution unit for the multicycle core, directly downstream of the main control FSM. It holds the NZCV status flags and evaluates the instruction's 4-bit condition field once per instruction, in the decode cycle. It then gates the FSM's raw write enables (NextPC/Branch, RegW, MemW, FPUW) into the architectural write strobes that drive the PC, register file, data memory and FPU register file.

---
 rtl/condunit.sv | 109 ++++++++++
 tb/tb_condunit.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/condunit.sv
// Conditional-execution unit for the multicycle core.
// Holds the NZCV flags, evaluates the condition field once per instruction in
// the decode cycle, and gates the FSM's raw write enables with the latched
// decision.
// Optional feature: define FPU_FLAGS_EN to let FPU compares write the flags.
module condunit (
  input  logic       clk,
  input  logic       reset,
  input  logic       IRWrite,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  input  logic [1:0] FlagW,
  input  logic       NextPC,
  input  logic       Branch,
  input  logic       RegW,
  input  logic       MemW,
  input  logic       FPUW,
  input  logic [3:0] FPUFlags,
  input  logic       FPUFlagW,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       FPUWrite,
  output logic [3:0] Flags,
  output logic       CondExReg
);

  logic [3:0] flags_q, flags_d;
  logic       cond_ex_q, cond_ex_d;
  logic       decode_q;
  logic       cond_ex;
  logic       flag_we;
  logic       n, z, c, v;

  assign {n, z, c, v} = flags_q;

  // Condition evaluation against the current flags
  always_comb begin
    cond_ex = 1'b1;
    unique case (Cond)
      4'b0000: cond_ex = z;
      4'b0001: cond_ex = ~z;
      4'b0010: cond_ex = c;
      4'b0011: cond_ex = ~c;
      4'b0100: cond_ex = n;
      4'b0101: cond_ex = ~n;
      4'b0110: cond_ex = v;
      4'b0111: cond_ex = ~v;
      4'b1000: cond_ex = c & ~z;
      4'b1001: cond_ex = ~c | z;
      4'b1010: cond_ex = (n == v);
      4'b1011: cond_ex = (n != v);
      4'b1100: cond_ex = ~z & (n == v);
      4'b1101: cond_ex = z | (n != v);
      4'b1110: cond_ex = 1'b1;
      4'b1111: cond_ex = 1'b1;
    endcase
  end

  // Latch the decision only at the end of decode; hold for the rest of the instruction
  always_comb begin
    cond_ex_d = cond_ex_q;
    if (decode_q) cond_ex_d = cond_ex;
  end

  // Flags are frozen during decode so evaluation and latch see the same value
  assign flag_we = cond_ex_q & ~decode_q;

  // Flag next-state; the FPU write, when built in, overrides the ALU halves
  always_comb begin
    flags_d = flags_q;
    if (flag_we) begin
      if (FlagW[1]) flags_d[3:2] = ALUFlags[3:2];
      if (FlagW[0]) flags_d[1:0] = ALUFlags[1:0];
`ifdef FPU_FLAGS_EN
      if (FPUFlagW) flags_d = FPUFlags;
`endif
    end
  end

`ifndef FPU_FLAGS_EN
  logic unused_fpu;
  assign unused_fpu = ^{FPUFlags, FPUFlagW};
`endif

  // State registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_q   <= 4'b0000;
      cond_ex_q <= 1'b0;
      decode_q  <= 1'b0;
    end else begin
      flags_q   <= flags_d;
      cond_ex_q <= cond_ex_d;
      decode_q  <= IRWrite;
    end
  end

  // Write-strobe gating, combinational with no added latency
  always_comb begin
    PCWrite   = NextPC | (Branch & cond_ex_q);
    RegWrite  = RegW & cond_ex_q;
    MemWrite  = MemW & cond_ex_q;
    FPUWrite  = FPUW & cond_ex_q;
    Flags     = flags_q;
    CondExReg = cond_ex_q;
  end

endmodule

// File: tb/tb_condunit.sv
// Directed self-checking bench for condunit.
module tb_condunit;

  logic       clk = 1'b0;
  logic       reset;
  logic       IRWrite;
  logic [3:0] Cond;
  logic [3:0] ALUFlags;
  logic [1:0] FlagW;
  logic       NextPC, Branch, RegW, MemW, FPUW;
  logic [3:0] FPUFlags;
  logic       FPUFlagW;
  logic       PCWrite, RegWrite, MemWrite, FPUWrite;
  logic [3:0] Flags;
  logic       CondExReg;

  int n_checks = 0;
  int n_pass   = 0;

  condunit dut (
    .clk      (clk),
    .reset    (reset),
    .IRWrite  (IRWrite),
    .Cond     (Cond),
    .ALUFlags (ALUFlags),
    .FlagW    (FlagW),
    .NextPC   (NextPC),
    .Branch   (Branch),
    .RegW     (RegW),
    .MemW     (MemW),
    .FPUW     (FPUW),
    .FPUFlags (FPUFlags),
    .FPUFlagW (FPUFlagW),
    .PCWrite  (PCWrite),
    .RegWrite (RegWrite),
    .MemWrite (MemWrite),
    .FPUWrite (FPUWrite),
    .Flags    (Flags),
    .CondExReg(CondExReg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", tag, got, exp);
  endtask

  // Advance one clock; inputs change 1 time unit after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    IRWrite = 0; FlagW = 2'b00; NextPC = 0; Branch = 0;
    RegW = 0; MemW = 0; FPUW = 0; FPUFlagW = 0;
  endtask

  // Fetch then decode with the given condition; returns in cycle D+1
  task automatic decode(input logic [3:0] cc);
    idle_inputs();
    IRWrite = 1; NextPC = 1; Cond = cc;
    step();
    IRWrite = 0; NextPC = 0;
    step();
  endtask

  // Load an arbitrary flag value via an AL instruction; leaves CondExReg=1
  task automatic set_flags(input logic [3:0] f);
    decode(4'b1110);
    FlagW = 2'b11; ALUFlags = f;
    step();
    FlagW = 2'b00;
  endtask

  typedef struct {logic [3:0] f; logic [3:0] cc; logic exp;} cvec_t;
  cvec_t cvecs[10];

  initial begin
    cvecs[0] = '{4'b0010, 4'b1000, 1'b1};  // HI
    cvecs[1] = '{4'b0110, 4'b1001, 1'b1};  // LS
    cvecs[2] = '{4'b1001, 4'b1010, 1'b1};  // GE
    cvecs[3] = '{4'b0100, 4'b1100, 1'b0};  // GT
    cvecs[4] = '{4'b0100, 4'b1101, 1'b1};  // LE
    cvecs[5] = '{4'b0000, 4'b1111, 1'b1};  // 1111 as AL
    cvecs[6] = '{4'b0001, 4'b0110, 1'b1};  // VS
    cvecs[7] = '{4'b1000, 4'b0101, 1'b0};  // PL
    cvecs[8] = '{4'b0010, 4'b0011, 1'b0};  // CC
    cvecs[9] = '{4'b1000, 4'b0100, 1'b1};  // MI

    idle_inputs();
    Cond = 4'b1110; ALUFlags = 4'b0000; FPUFlags = 4'b0000;
    reset = 1;
    step();
    reset = 0;
    check("reset_flags", Flags, 4'b0000);

    // Asynchronous reset mid-cycle with flags at 1111
    set_flags(4'b1111);
    check("flags_1111", Flags, 4'b1111);
    #2 reset = 1;
    #1;
    check("async_rst_flags", Flags, 4'b0000);
    check("async_rst_condex", {3'b0, CondExReg}, 4'b0000);
    RegW = 1; NextPC = 0;
    #1;
    check("rst_regwrite", {3'b0, RegWrite}, 4'b0000);
    check("rst_pcwrite", {3'b0, PCWrite}, 4'b0000);
    NextPC = 1;
    #1;
    check("rst_pcwrite_nextpc", {3'b0, PCWrite}, 4'b0001);
    #1 reset = 0;
    idle_inputs();
    step();
    // Stale strobe after reset release is suppressed until next decode
    RegW = 1;
    #1;
    check("post_rst_regwrite", {3'b0, RegWrite}, 4'b0000);

    // EQ taken / NE not taken
    set_flags(4'b0100);
    decode(4'b0000);
    RegW = 1;
    #1;
    check("eq_regwrite", {3'b0, RegWrite}, 4'b0001);
    decode(4'b0001);
    RegW = 1;
    #1;
    check("ne_regwrite", {3'b0, RegWrite}, 4'b0000);

    // Fetch cycle: PCWrite=NextPC while CondExReg holds the old decision (0)
    idle_inputs();
    IRWrite = 1; NextPC = 1; Cond = 4'b0000;
    #1;
    check("fetch_pcwrite", {3'b0, PCWrite}, 4'b0001);
    check("fetch_old_condex", {3'b0, CondExReg}, 4'b0000);
    step();

    // Conditional branch LT
    set_flags(4'b0000);
    decode(4'b1011);
    Branch = 1;
    #1;
    check("lt_not_taken", {3'b0, PCWrite}, 4'b0000);
    set_flags(4'b1000);
    decode(4'b1011);
    Branch = 1;
    #1;
    check("lt_taken", {3'b0, PCWrite}, 4'b0001);

    // Split flag writes
    set_flags(4'b0000);
    ALUFlags = 4'b1111; FlagW = 2'b10;
    step();
    check("split_nz", Flags, 4'b1100);
    FlagW = 2'b01;
    step();
    check("split_cv", Flags, 4'b1111);

    // Suppressed instruction: flag write and strobes in the same cycle
    set_flags(4'b0000);
    decode(4'b0000);
    FlagW = 2'b11; ALUFlags = 4'b0100; MemW = 1; FPUW = 1;
    #1;
    check("supp_memwrite", {3'b0, MemWrite}, 4'b0000);
    check("supp_fpuwrite", {3'b0, FPUWrite}, 4'b0000);
    step();
    check("supp_flags", Flags, 4'b0000);

    // Flag write requested during the decode cycle is ignored
    set_flags(4'b0000);
    decode(4'b1110);
    IRWrite = 1; Cond = 4'b1110;
    step();
    IRWrite = 0; FlagW = 2'b11; ALUFlags = 4'b1111;
    step();
    check("decode_flag_ignored", Flags, 4'b0000);
    FlagW = 2'b00;

    // IRWrite held for consecutive cycles reloads CondExReg each cycle
    set_flags(4'b0100);
    decode(4'b1110);
    IRWrite = 1; Cond = 4'b0000;
    step();
    Cond = 4'b0001;
    step();
    check("back2back_ne", {3'b0, CondExReg}, 4'b0000);
    IRWrite = 0; Cond = 4'b0000;
    step();
    check("back2back_eq", {3'b0, CondExReg}, 4'b0001);

    // Condition table vectors
    for (int i = 0; i < 10; i++) begin
      set_flags(cvecs[i].f);
      decode(cvecs[i].cc);
      check($sformatf("cond_%b_flags_%b", cvecs[i].cc, cvecs[i].f),
            {3'b0, CondExReg}, {3'b0, cvecs[i].exp});
    end

    // FPU flag update priority
    set_flags(4'b0000);
    FPUFlagW = 1; FPUFlags = 4'b0110; FlagW = 2'b11; ALUFlags = 4'b1001; FPUW = 1;
    #1;
    check("fpuwrite_gated", {3'b0, FPUWrite}, 4'b0001);
    step();
`ifdef FPU_FLAGS_EN
    check("fpu_flags", Flags, 4'b0110);
`else
    check("fpu_flags", Flags, 4'b1001);
`endif
    idle_inputs();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
